sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock synchronous FIFO buffer: stores data words written on `wr` and returns them in first-in first-out order on `rd`.
- Provides `empty` and `full` status flags for producer/consumer flow control.
- Used as a generic elastic buffer between two blocks in the same clock domain, and as the standard FIFO verification target for the transaction-level environment (interface bundle plus generator/driver/monitor/scoreboard).

Parameters:
- DATA_WIDTH, 8, width of `data_in` / `data_out` in bits.
- DEPTH, 16, number of storage entries. Must be a power of two, at least 2.
- ADDR_WIDTH, log2(DEPTH) = 4, pointer width. Derived; not overridden independently.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-high reset. Asserted (1) at a rising clk edge, it resets the block. The name is kept as-is despite the high polarity.
- rd  input  1  read request, sampled on the rising edge.
- wr  input  1  write request, sampled on the rising edge.
- data_in  input  DATA_WIDTH  write data, captured when a write is accepted.
- data_out  output  DATA_WIDTH  registered read data.
- empty  output  1  high when occupancy is 0.
- full  output  1  high when occupancy equals DEPTH.

Behaviour:
- Internal state:
  - storage array of DEPTH x DATA_WIDTH.
  - write pointer and read pointer, each ADDR_WIDTH bits, wrapping modulo DEPTH.
  - occupancy count, ADDR_WIDTH+1 bits, range 0..DEPTH.
- Reset (rst_n=1 at a rising edge):
  - pointers = 0, count = 0, data_out = 0.
  - empty = 1, full = 0.
  - Reset overrides rd/wr in the same cycle; storage contents are don't-care.
  - Reset mid-operation discards all stored data.
- Flags are combinational decodes of the registered count: empty = (count==0), full = (count==DEPTH). They change in the cycle after the causing edge, with no extra latency.
- Write acceptance, wr_ok = wr & (!full | rd_ok):
  - mem[wptr] <= data_in; wptr increments, wrapping DEPTH-1 -> 0.
- Read acceptance, rd_ok = rd & !empty:
  - data_out <= mem[rptr]; rptr increments with wrap.
  - Read latency is 1 clock: data is valid on data_out after the edge that accepts rd.
  - data_out holds its last value when no read is accepted. There is no first-word fall-through.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither are accepted.
- Boundary cases:
  - wr while full with no rd: write ignored; data, pointers and count unchanged; no error flag.
  - rd while empty: ignored; data_out holds; count stays 0.
  - rd & wr while empty: only the write is accepted. count -> 1, data_out unchanged (no read-through).
  - rd & wr while full: both accepted. The oldest word is output, the new word is stored, full stays 1.
  - rd & wr with 0<count<DEPTH: both accepted; count unchanged.
  - Pointer wrap-around is seamless; ordering is preserved across any number of wraps.
- No X propagation: data_out is never X after reset.

Test Plan:
- Reset: hold rst_n=1 for 2 edges with rd=wr=1 -> empty=1, full=0, data_out=0; no write has occurred (a following rd leaves data_out=0).
- Fill/overflow: write 0x01..0x10 (16 words) -> full=1 after the 16th edge. A 17th write of 0xAA is ignored. Draining 16 reads returns 0x01..0x10 in order, each one cycle after its rd edge; empty=1 after the last read.
- Underflow: on an empty FIFO pulse rd 3 times -> data_out holds its previous value, empty stays 1, and a later write/read of 0x5C returns 0x5C.
- Simultaneous: with count=4 (0x10..0x13), assert rd&wr with 0x20 for 4 cycles -> outputs 0x10..0x13, count stays 4, then drain yields 0x20 x4. With the FIFO full, rd&wr keeps full=1 and outputs the oldest word.
- Wrap-around: 40 interleaved random write/read transactions (generator count 20 each) -> scoreboard matches every word in order, with pointers wrapping at 16.
- Mid-operation reset: with count=7, assert rst_n=1 for one edge -> empty=1, full=0, data_out=0. A subsequent single write of 0x3C reads back 0x3C, not stale data.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and count-derived empty/full flags.
// rst_n is active-high despite its name and is sampled synchronously.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  rd_ok;
    logic                  wr_ok;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A read frees the slot in the same edge, so a full FIFO still accepts a write alongside it.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (!rst_n && wr_ok) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                data_out <= mem[rptr];
                rptr     <= rptr + ADDR_WIDTH'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus queues expected read data, a monitor
// compares data_out after every edge (reset value, accepted read, or hold).
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       rd;
    logic       wr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    logic       rd_expected;
    logic [7:0] exp_q [$];
    logic [7:0] model_q [$];
    logic [7:0] last_out;
    int         checks;
    int         errors;

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd       (rd),
        .wr       (wr),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    // Monitor: every edge either resets data_out, presents the next queued word, or holds.
    always @(posedge clk) begin
        logic       s_rst;
        logic       s_rd;
        logic [7:0] exp;
        s_rst = rst_n;
        s_rd  = rd_expected;
        #1;
        if (s_rst) begin
            exp = 8'h00;
        end else if (s_rd) begin
            if (exp_q.size() == 0) begin
                exp = last_out;
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_underrun no expected word queued, data_out=%h", data_out);
            end else begin
                exp = exp_q.pop_front();
            end
        end else begin
            exp = last_out;
        end
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("[TB] FAIL data_out rst=%0b rd=%0b got %h expected %h at %0t",
                     s_rst, s_rd, data_out, exp, $time);
        end
        last_out = exp;
    end

    task automatic applyStimulus(input logic r_rst, input logic r_rd, input logic r_wr,
                                 input logic [7:0] d, input logic exp_rd,
                                 input logic [7:0] exp_data);
        @(negedge clk);
        rst_n       = r_rst;
        rd          = r_rd;
        wr          = r_wr;
        data_in     = d;
        rd_expected = exp_rd;
        if (exp_rd) exp_q.push_back(exp_data);
        @(posedge clk);
    endtask

    task automatic checkOutput(input string name, input logic exp_empty, input logic exp_full);
        #2;
        checks++;
        if (empty !== exp_empty || full !== exp_full) begin
            errors++;
            $display("[TB] FAIL %s empty/full got %b/%b expected %b/%b",
                     name, empty, full, exp_empty, exp_full);
        end
    endtask

    initial begin
        logic [7:0] v;
        clk         = 1'b0;
        rst_n       = 1'b1;
        rd          = 1'b0;
        wr          = 1'b0;
        data_in     = 8'h00;
        rd_expected = 1'b0;
        last_out    = 8'h00;
        checks      = 0;
        errors      = 0;

        // Reset with rd/wr asserted: nothing may be written.
        applyStimulus(1, 1, 1, 8'h77, 0, 8'h00);
        applyStimulus(1, 1, 1, 8'h77, 0, 8'h00);
        checkOutput("reset_flags", 1, 0);
        applyStimulus(0, 1, 0, 8'h00, 0, 8'h00);
        checkOutput("reset_no_write", 1, 0);

        // Fill to full, overflow attempt, then drain in order.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 0, 1, 8'(i), 0, 8'h00);
            if (i == 1)  checkOutput("fill_first", 0, 0);
            if (i == 15) checkOutput("fill_15", 0, 0);
        end
        checkOutput("fill_full", 0, 1);
        applyStimulus(0, 0, 1, 8'hAA, 0, 8'h00);
        checkOutput("overflow_ignored", 0, 1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1, 0, 8'h00, 1, 8'(i));
            if (i == 1) checkOutput("drain_first", 0, 0);
        end
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
        checkOutput("drain_empty", 1, 0);

        // Underflow: reads on empty hold data_out at 0x10.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'h00, 0, 8'h00);
        checkOutput("underflow_empty", 1, 0);
        applyStimulus(0, 0, 1, 8'h5C, 0, 8'h00);
        applyStimulus(0, 1, 0, 8'h00, 1, 8'h5C);
        checkOutput("underflow_recover", 1, 0);

        // Simultaneous rd&wr on an empty FIFO accepts only the write.
        applyStimulus(0, 1, 1, 8'h44, 0, 8'h00);
        checkOutput("rdwr_empty", 0, 0);
        applyStimulus(0, 1, 0, 8'h00, 1, 8'h44);

        // Simultaneous rd&wr at count=4.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 8'h10 + 8'(i), 0, 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 8'h20, 1, 8'h10 + 8'(i));
        checkOutput("rdwr_mid", 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'h00, 1, 8'h20);
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
        checkOutput("rdwr_mid_drained", 1, 0);

        // Simultaneous rd&wr while full keeps full and outputs the oldest word.
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 8'h30 + 8'(i), 0, 8'h00);
        applyStimulus(0, 1, 1, 8'hF0, 1, 8'h30);
        checkOutput("rdwr_full", 0, 1);
        for (int i = 1; i < 16; i++) applyStimulus(0, 1, 0, 8'h00, 1, 8'h30 + 8'(i));
        applyStimulus(0, 1, 0, 8'h00, 1, 8'hF0);
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
        checkOutput("rdwr_full_drained", 1, 0);

        // Wrap-around: 20 writes and 20 reads interleaved, expected words from a bench queue.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 2; k++) begin
                v = 8'($urandom_range(0, 255));
                model_q.push_back(v);
                applyStimulus(0, 0, 1, v, 0, 8'h00);
            end
            for (int k = 0; k < 2; k++) begin
                v = model_q.pop_front();
                applyStimulus(0, 1, 0, 8'h00, 1, v);
            end
        end
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
        checkOutput("wrap_empty", 1, 0);

        // Mid-operation reset discards stored words.
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 8'h60 + 8'(i), 0, 8'h00);
        checkOutput("pre_reset_count7", 0, 0);
        applyStimulus(1, 0, 0, 8'h00, 0, 8'h00);
        checkOutput("mid_reset_flags", 1, 0);
        applyStimulus(0, 0, 1, 8'h3C, 0, 8'h00);
        checkOutput("post_reset_write", 0, 0);
        applyStimulus(0, 1, 0, 8'h00, 1, 8'h3C);
        checkOutput("post_reset_read", 1, 0);

        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 0, 8'h00);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover got %0d queued expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
